// File: rtl/mux16_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter_if
// Bundle of request/grant/select signals between the 16 requesters and the
// round-robin arbiter that owns the 16:1 mux select.
//
//   req       [15:0]  request vector, one bit per requester
//   grant     [15:0]  one-hot grant, zero when idle
//   sel       [3:0]   binary index of current owner, wired to mux sel
//   valid             high while a grant is active
//   grant_new         one-cycle pulse on the first cycle of each new grant
//
// modport master : requester side (drives req, observes the grant outputs)
// modport slave  : arbiter side (samples req, drives the grant outputs)
// ---------------------------------------------------------------------------
interface mux16_rr_arbiter_if;

    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic        grant_new;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  valid,
        input  grant_new
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output valid,
        output grant_new
    );

endinterface

// File: rtl/mux16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter and select controller for a 16:1 single-bit mux.
// One requester owns the mux at a time; its index drives the mux select.
// An owner that has held the grant for MAX_HOLD cycles is preempted as soon
// as anyone else is waiting, which bounds the wait of any requester.
//
// Parameters
//   MAX_HOLD  consecutive cycles an owner keeps the grant under contention
//             (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   slave side of mux16_rr_arbiter_if (req in; grant, sel, valid,
//         grant_new out, all registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner, grant = 0, sel holds its last value
// BUSY  | owner = sel, grant = 1 << sel
// ---------------------------------------------------------------------------
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux16_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q,     state_d;
    logic [15:0]      grant_q,     grant_d;
    logic [3:0]       sel_q,       sel_d;
    logic [3:0]       last_q,      last_d;
    logic [CNT_W-1:0] hold_q,      hold_d;
    logic             grant_new_q, grant_new_d;

    logic [15:0]      others;
    logic [4:0]       pick_all;
    logic [4:0]       pick_others;

    // Search last+1, last+2, ... modulo 16 and return {found, index} of the
    // first set bit. The 4-bit add wraps 15 to 0 for free.
    function automatic logic [4:0] rr_pick(input logic [15:0] r,
                                           input logic [3:0]  last);
        logic       found;
        logic [3:0] win;
        logic [3:0] idx;
        found = 1'b0;
        win   = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = last + 4'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Requests other than the current owner; only meaningful in BUSY.
    assign others      = bus.req & ~(16'h0001 << sel_q);
    assign pick_all    = rr_pick(bus.req, last_q);
    assign pick_others = rr_pick(others, last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= 4'd0;
            last_q      <= 4'd15;
            hold_q      <= '0;
            grant_new_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            grant_new_q <= grant_new_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        last_d      = last_q;
        hold_d      = hold_q;
        grant_new_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_all[4]) begin
                    state_d     = BUSY;
                    grant_d     = 16'h0001 << pick_all[3:0];
                    sel_d       = pick_all[3:0];
                    last_d      = pick_all[3:0];
                    hold_d      = '0;
                    grant_new_d = 1'b1;
                end
            end

            BUSY: begin
                if (!bus.req[sel_q]) begin
                    // Owner released: hand off in the same edge, or go idle.
                    if (pick_all[4]) begin
                        grant_d     = 16'h0001 << pick_all[3:0];
                        sel_d       = pick_all[3:0];
                        last_d      = pick_all[3:0];
                        hold_d      = '0;
                        grant_new_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LAST && pick_others[4]) begin
                    // Hold limit reached with someone waiting: preempt.
                    grant_d     = 16'h0001 << pick_others[3:0];
                    sel_d       = pick_others[3:0];
                    last_d      = pick_others[3:0];
                    hold_d      = '0;
                    grant_new_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    // Saturating, so a lone owner holds indefinitely and is
                    // preempted on the first edge a competitor shows up.
                    hold_d = hold_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.valid     = (state_q == BUSY);
    assign bus.grant_new = grant_new_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

    localparam int MH    = 4;
    localparam int BOUND = 15 * MH + 1;

    logic clk;
    logic rst;

    mux16_rr_arbiter_if bus ();

    mux16_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner index (-1 when nobody holds the mux), the most
    // recent owner, the select value, and how many cycles the owner has
    // held the grant so far.
    int m_owner = -1;
    int m_last  = 15;
    int m_sel   = 0;
    int m_held  = 0;
    bit m_gnew  = 1'b0;

    int wait_cnt [16];
    int max_wait = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++) begin
            int i;
            i = (last + k) % 16;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic ref_take(input int w);
        m_owner = w;
        m_sel   = w;
        m_last  = w;
        m_held  = 1;
        m_gnew  = 1'b1;
    endtask

    task automatic ref_step(input logic [15:0] r, input logic rs);
        int w;
        logic [15:0] oth;
        if (rs) begin
            m_owner = -1;
            m_last  = 15;
            m_sel   = 0;
            m_held  = 0;
            m_gnew  = 1'b0;
            return;
        end
        m_gnew = 1'b0;
        if (m_owner < 0) begin
            w = ref_pick(r, m_last);
            if (w >= 0) ref_take(w);
        end else if (!r[m_owner]) begin
            w = ref_pick(r, m_last);
            if (w >= 0) ref_take(w);
            else        m_owner = -1;
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (m_held >= MH && oth != 16'h0) ref_take(ref_pick(oth, m_last));
            else                              m_held++;
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare 1 time unit later.
    task automatic step(input logic [15:0] r, input logic rs);
        logic [15:0] exp_grant;
        @(negedge clk);
        bus.req = r;
        rst     = rs;
        @(posedge clk);
        ref_step(r, rs);
        #1;
        exp_grant = (m_owner < 0) ? 16'h0 : (16'h0001 << m_owner);
        chk("grant",     32'(bus.grant),     32'(exp_grant));
        chk("sel",       32'(bus.sel),       32'(m_sel));
        chk("valid",     32'(bus.valid),     32'(m_owner >= 0));
        chk("grant_new", 32'(bus.grant_new), 32'(m_gnew));
        chk("onehot0",   32'($onehot0(bus.grant)), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (rs || !r[i] || bus.grant[i]) wait_cnt[i] = 0;
            else                             wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
    endtask

    initial begin
        logic [15:0] rq;
        int gn;
        rst     = 1'b1;
        bus.req = 16'h0;
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;

        // Reset then idle
        step(16'h0, 1'b1);
        step(16'h0, 1'b1);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_sel",   32'(bus.sel),   32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        step(16'h0, 1'b0);

        // Single request, then drop
        step(16'h0020, 1'b0);
        chk("single_sel",  32'(bus.sel),       32'd5);
        chk("single_gnew", 32'(bus.grant_new), 32'd1);
        step(16'h0020, 1'b0);
        chk("single_gnew_once", 32'(bus.grant_new), 32'd0);
        step(16'h0000, 1'b0);
        chk("drop_grant", 32'(bus.grant), 32'h0);
        chk("drop_sel",   32'(bus.sel),   32'd5);

        // Round robin between 0 and 15 after reset
        step(16'h0, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step(16'h8001, 1'b0);
            if (c == 1) chk("rr_first", 32'(bus.sel), 32'd0);
            if (c == 4) chk("rr_hold",  32'(bus.sel), 32'd0);
            if (c == 5) begin
                chk("rr_pre15",      32'(bus.sel),       32'd15);
                chk("rr_pre15_gnew", 32'(bus.grant_new), 32'd1);
            end
            if (c == 9) chk("rr_wrap0", 32'(bus.sel), 32'd0);
        end

        // Release handoff from owner 3 to 9 with no bubble
        step(16'h0, 1'b1);
        step(16'h0008, 1'b0);
        step(16'h0208, 1'b0);
        chk("handoff_pre", 32'(bus.sel), 32'd3);
        step(16'h0200, 1'b0);
        chk("handoff_sel",   32'(bus.sel),       32'd9);
        chk("handoff_gnew",  32'(bus.grant_new), 32'd1);
        chk("handoff_valid", 32'(bus.valid),     32'd1);

        // Lone holder, then a competitor arrives after saturation
        step(16'h0, 1'b1);
        gn = 0;
        for (int c = 0; c < 50; c++) begin
            step(16'h0100, 1'b0);
            if (bus.grant_new) gn++;
        end
        chk("lone_gnew_count", 32'(gn),      32'd1);
        chk("lone_sel",        32'(bus.sel), 32'd8);
        step(16'h0104, 1'b0);
        chk("lone_preempt", 32'(bus.sel), 32'd2);

        // Reset mid-grant
        step(16'h0104, 1'b1);
        chk("midrst_grant", 32'(bus.grant), 32'h0);
        chk("midrst_sel",   32'(bus.sel),   32'h0);
        chk("midrst_valid", 32'(bus.valid), 32'h0);

        // Random soak
        rq = 16'h0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 16; b++)
                if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
            if ($urandom_range(0, 7) == 0) rq = 16'(1) << $urandom_range(0, 15);
            step(rq, ($urandom_range(0, 999) == 0));
        end
        chk("max_wait_bound", 32'(max_wait <= BOUND), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
